mem_port_ctrl: RTL

Memory-side responder for the commit and load paths. Accepts committed stores (byte/half/word) from the reorder buffer and load requests from the load/store buffer, serialises each into byte-wide RAM accesses, and returns load results tagged with their ROB dependency id. Sits between the ROB/LSB and the single byte-wide RAM port; owns `mem_busy`, `mem_valid`, `mem_dependency` and `mem_value` as seen by the ROB.

---
 rtl/mem_port_ctrl_pkg.sv | 39 +++
 rtl/mem_port_ctrl_load_extend.sv | 23 ++
 rtl/mem_port_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_ctrl_pkg.sv
// mem_port_ctrl shared types: access-size encodings,
// FSM state encoding and the default ROB index width.
package mem_port_ctrl_pkg;

  localparam int DEF_ROB_SIZE_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_B = 2'b00,
    ST_H = 2'b01,
    ST_W = 2'b10
  } st_type_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_type_e;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    LOAD,
    LOAD_TAIL
  } state_e;

  // index of the last byte of an access (len-1)
  function automatic logic [1:0] last_idx(
    input logic [1:0] sz
  );
    unique case (sz)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_ctrl_load_extend.sv
// mem_port_ctrl load result extension:
// sign/zero extends the assembled raw load word.
module load_extend
  import mem_port_ctrl_pkg::*;
(
  input  logic [2:0]  ty_i,
  input  logic [31:0] raw_i,
  output logic [31:0] val_o
);

  // pick the extension by load type; LW passes through
  always_comb begin
    val_o = raw_i;
    case (ty_i)
      LD_B:  val_o = {{24{raw_i[7]}}, raw_i[7:0]};
      LD_H:  val_o = {{16{raw_i[15]}}, raw_i[15:0]};
      LD_BU: val_o = {24'd0, raw_i[7:0]};
      LD_HU: val_o = {16'd0, raw_i[15:0]};
      default: val_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: serialises committed stores and
// loads onto a byte-wide RAM port, returns tagged loads.
module mem_port_ctrl #(
  parameter int ROB_SIZE_WIDTH =
    mem_port_ctrl_pkg::DEF_ROB_SIZE_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      st_valid_in,
  input  logic [1:0]                st_type_in,
  input  logic [31:0]               st_addr_in,
  input  logic [31:0]               st_data_in,
  input  logic                      ld_valid_in,
  input  logic [2:0]                ld_type_in,
  input  logic [31:0]               ld_addr_in,
  input  logic [ROB_SIZE_WIDTH:0]   ld_dep_in,
  output logic                      ld_ready_out,
  output logic                      mem_busy_out,
  output logic                      mem_valid_out,
  output logic [ROB_SIZE_WIDTH:0]   mem_dependency_out,
  output logic [31:0]               mem_value_out,
  output logic [31:0]               ram_a_out,
  output logic [7:0]                ram_dout_out,
  output logic                      ram_wr_out,
  input  logic [7:0]                ram_din_in
);
  import mem_port_ctrl_pkg::*;

  localparam int TW = ROB_SIZE_WIDTH + 1;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d, cnt_n;
  logic [1:0]      lst_q, lst_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [2:0]      lty_q, lty_d;
  logic [TW-1:0]   dep_q, dep_d;
  logic [31:0]     asm_q, asm_d;
  logic [1:0]      cap_idx;
  logic [31:0]     ext;
  logic            mv_q, mv_d;
  logic [TW-1:0]   mdep_q, mdep_d;
  logic [31:0]     mval_q, mval_d;
  logic [31:0]     ra_q, ra_d;
  logic [7:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic            ld_go;

  assign ld_ready_out = rdy_in && state_q == IDLE &&
                        !st_valid_in && !flush_in;
  assign mem_busy_out = state_q != IDLE || st_valid_in;
  assign ld_go        = ld_valid_in && ld_ready_out;

  assign mem_valid_out      = mv_q;
  assign mem_dependency_out = mdep_q;
  assign mem_value_out      = mval_q;
  assign ram_a_out          = ra_q;
  assign ram_dout_out       = rd_q;
  assign ram_wr_out         = rw_q;

  load_extend u_ext (
    .ty_i  (lty_q),
    .raw_i (asm_d),
    .val_o (ext)
  );

  // gather the byte returned for the previous address
  always_comb begin
    asm_d   = asm_q;
    cap_idx = (state_q == LOAD_TAIL) ? cnt_q
                                     : cnt_q - 2'd1;
    if ((state_q == LOAD && cnt_q != 2'd0) ||
        state_q == LOAD_TAIL)
      asm_d[{cap_idx, 3'b000} +: 8] = ram_din_in;
    if (state_q == IDLE)
      asm_d = '0;
  end

  // next state, RAM port and result registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lst_d   = lst_q;
    addr_d  = addr_q;
    data_d  = data_q;
    lty_d   = lty_q;
    dep_d   = dep_q;
    mv_d    = 1'b0;
    mdep_d  = mdep_q;
    mval_d  = mval_q;
    ra_d    = ra_q;
    rd_d    = rd_q;
    rw_d    = 1'b0;
    cnt_n   = cnt_q + 2'd1;
    unique case (state_q)
      IDLE: begin
        if (st_valid_in) begin
          addr_d  = st_addr_in;
          data_d  = st_data_in;
          lst_d   = last_idx(st_type_in);
          cnt_d   = 2'd0;
          state_d = STORE;
          rw_d    = 1'b1;
          ra_d    = st_addr_in;
          rd_d    = st_data_in[7:0];
        end else if (ld_go) begin
          addr_d  = ld_addr_in;
          lty_d   = ld_type_in;
          dep_d   = ld_dep_in;
          lst_d   = last_idx(ld_type_in[1:0]);
          cnt_d   = 2'd0;
          state_d = LOAD;
          ra_d    = ld_addr_in;
        end
      end
      STORE: begin
        if (cnt_q == lst_q) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_n;
          rw_d  = 1'b1;
          ra_d  = addr_q + {30'd0, cnt_n};
          rd_d  = data_q[{cnt_n, 3'b000} +: 8];
        end
      end
      LOAD: begin
        if (flush_in) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else if (cnt_q == lst_q) begin
          state_d = LOAD_TAIL;
        end else begin
          cnt_d = cnt_n;
          ra_d  = addr_q + {30'd0, cnt_n};
        end
      end
      LOAD_TAIL: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
        if (!flush_in) begin
          mv_d   = 1'b1;
          mdep_d = dep_q;
          mval_d = ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state update; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lst_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      lty_q   <= '0;
      dep_q   <= '0;
      asm_q   <= '0;
      mv_q    <= 1'b0;
      mdep_q  <= '0;
      mval_q  <= '0;
      ra_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lst_q   <= lst_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lty_q   <= lty_d;
      dep_q   <= dep_d;
      asm_q   <= asm_d;
      mv_q    <= mv_d;
      mdep_q  <= mdep_d;
      mval_q  <= mval_d;
      ra_q    <= ra_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
    end
  end

endmodule
